alu_seq_flags: RTL

//   Parametrised, registered successor of the 16-bit combinational add/sub ALU.

---
 rtl/alu_seq_flags_if.sv | 36 +++
 rtl/alu_seq_flags.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_flags_if.sv
// Request/result handshake bundle for the sequential flag-keeping ALU.
interface alu_seq_flags_if #(
  parameter int unsigned WIDTH = 16
);

  // Request side
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             clr_flags;

  // Result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Z;
  logic             N;
  logic             V;
  logic             C;

  // Requester / result consumer
  modport master (
    output in_valid, op, A, B, Cin, clr_flags, out_ready,
    input  in_ready, out_valid, S, Z, N, V, C
  );

  // The ALU itself
  modport slave (
    input  in_valid, op, A, B, Cin, clr_flags, out_ready,
    output in_ready, out_valid, S, Z, N, V, C
  );

endinterface

// File: rtl/alu_seq_flags.sv
// Registered add/sub/logic/shift ALU with a persistent Z/N/V/C flag register.
// Single-cycle ops load at the accept edge; non-zero shifts iterate one bit
// per cycle and load on the edge the down-counter expires.
module alu_seq_flags #(
  parameter int unsigned WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_flags_if.slave bus
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_ADC = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_SAR = 4'd10;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_e;

  state_e           state;
  logic             out_valid_q;
  logic [WIDTH-1:0] s_q;
  logic             z_q;
  logic             n_q;
  logic             v_q;
  logic             c_q;
  logic [WIDTH-1:0] work_q;
  logic [SHW-1:0]   cnt_q;
  logic [3:0]       sh_op_q;
  logic             clr_q;

  logic             accept;
  logic [SHW-1:0]   amt;
  logic             is_shift;
  logic             carry_in;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] imm_s;
  logic             imm_zn_upd;
  logic             imm_z;
  logic             imm_n;
  logic             imm_v;
  logic             imm_c;
  logic [WIDTH-1:0] sh_next;
  logic             sh_out;

  assign bus.in_ready  = (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.S         = s_q;
  assign bus.Z         = z_q;
  assign bus.N         = n_q;
  assign bus.V         = v_q;
  assign bus.C         = c_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign amt      = bus.B[SHW-1:0];
  assign is_shift = (bus.op == OP_SHL) || (bus.op == OP_SHR) || (bus.op == OP_SAR);

  // Single-cycle result and flags from the request; carry ops read the stored C.
  always_comb begin
    carry_in   = 1'b0;
    sum        = '0;
    imm_s      = bus.A;
    imm_zn_upd = 1'b1;
    imm_v      = v_q;
    imm_c      = c_q;
    case (bus.op)
      OP_ADD, OP_ADC: begin
        carry_in = (bus.op == OP_ADC) ? c_q : bus.Cin;
        sum      = {1'b0, bus.A} + {1'b0, bus.B} + (WIDTH+1)'(carry_in);
        imm_s    = sum[WIDTH-1:0];
        imm_c    = sum[WIDTH];
        imm_v    = ~(bus.A[WIDTH-1] ^ bus.B[WIDTH-1]) & (bus.A[WIDTH-1] ^ sum[WIDTH-1]);
      end
      OP_SUB, OP_SBC: begin
        carry_in = (bus.op == OP_SBC) ? ~c_q : bus.Cin;
        sum      = {1'b0, bus.A} - {1'b0, bus.B} - (WIDTH+1)'(carry_in);
        imm_s    = sum[WIDTH-1:0];
        imm_c    = ~sum[WIDTH];
        imm_v    = (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]) & (bus.A[WIDTH-1] ^ sum[WIDTH-1]);
      end
      OP_AND: begin
        imm_s = bus.A & bus.B;
        imm_v = 1'b0;
      end
      OP_OR: begin
        imm_s = bus.A | bus.B;
        imm_v = 1'b0;
      end
      OP_XOR: begin
        imm_s = bus.A ^ bus.B;
        imm_v = 1'b0;
      end
      OP_SHL, OP_SHR, OP_SAR: begin
        // Only reached as an immediate load when the amount is zero: pass A, keep C.
        imm_v = 1'b0;
      end
      default: begin
        imm_zn_upd = 1'b0;
      end
    endcase
    imm_z = imm_zn_upd ? (imm_s == '0) : z_q;
    imm_n = imm_zn_upd ? imm_s[WIDTH-1] : n_q;
  end

  // One-bit shift step of the working register and the bit leaving it.
  always_comb begin
    sh_next = {1'b0, work_q[WIDTH-1:1]};
    sh_out  = work_q[0];
    case (sh_op_q)
      OP_SHL: begin
        sh_next = {work_q[WIDTH-2:0], 1'b0};
        sh_out  = work_q[WIDTH-1];
      end
      OP_SAR: begin
        sh_next = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        sh_out  = work_q[0];
      end
      default: begin
        sh_next = {1'b0, work_q[WIDTH-1:1]};
        sh_out  = work_q[0];
      end
    endcase
  end

  // Control FSM with result, flag and shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
      c_q         <= 1'b0;
      work_q      <= '0;
      cnt_q       <= '0;
      sh_op_q     <= OP_SHL;
      clr_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_shift && (amt != '0)) begin
              state       <= ST_SHIFT;
              work_q      <= bus.A;
              cnt_q       <= amt;
              sh_op_q     <= bus.op;
              clr_q       <= bus.clr_flags;
              out_valid_q <= 1'b0;
            end else begin
              s_q         <= imm_s;
              out_valid_q <= 1'b1;
              if (bus.clr_flags) begin
                z_q <= 1'b0;
                n_q <= 1'b0;
                v_q <= 1'b0;
                c_q <= 1'b0;
              end else begin
                z_q <= imm_z;
                n_q <= imm_n;
                v_q <= imm_v;
                c_q <= imm_c;
              end
            end
          end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        ST_SHIFT: begin
          work_q <= sh_next;
          cnt_q  <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            state       <= ST_IDLE;
            s_q         <= sh_next;
            out_valid_q <= 1'b1;
            if (clr_q) begin
              z_q <= 1'b0;
              n_q <= 1'b0;
              v_q <= 1'b0;
              c_q <= 1'b0;
            end else begin
              z_q <= (sh_next == '0);
              n_q <= sh_next[WIDTH-1];
              v_q <= 1'b0;
              c_q <= sh_out;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
